gray_fifo_ptr: RTL

Parametrised Gray-code pointer unit for one side of a dual-clock FIFO. It is the generalised successor of the plain enable-driven Gray counter. It keeps a binary and a Gray pointer one bit wider than the address, synchronises the opposite side's Gray pointer into the local clock domain, and produces the full or empty flag, an almost flag, a fill level and a sticky overflow/underflow error. Two instances, one per clock domain, sit around a dual-port RAM in the DMA test FIFOs.

---
 rtl/gray_fifo_pkg.sv | 48 ++++
 rtl/gray_sync.sv | 34 +++
 rtl/gray_fifo_ptr.sv | 116 +++++++++++
 3 files changed

// File: rtl/gray_fifo_pkg.sv
// gray_fifo_pkg: shared definitions for the dual-clock FIFO Gray pointer units.
//   - SIDE_RD / SIDE_WR : side selectors for gray_fifo_ptr.
//   - fifo_depth()      : DEPTH from an address width.
//   - bin2gray()/gray2bin(): code conversion on a 32-bit container, masked to a
//                          caller-supplied width.
package gray_fifo_pkg;

    localparam int unsigned SIDE_RD = 0;
    localparam int unsigned SIDE_WR = 1;

    localparam int unsigned MAX_PTR_W = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_word_t;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    function automatic ptr_word_t width_mask(input int unsigned width);
        ptr_word_t mask;
        if (width >= MAX_PTR_W) begin
            mask = '1;
        end else begin
            mask = (ptr_word_t'(1) << width) - ptr_word_t'(1);
        end
        return mask;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t bin, input int unsigned width);
        ptr_word_t b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it; bits above
    // the masked width are zero so a full-container prefix XOR is exact.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray, input int unsigned width);
        ptr_word_t g;
        ptr_word_t b;
        g = gray & width_mask(width);
        b = g;
        for (int i = 1; i < MAX_PTR_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// gray_sync: multi-flop synchroniser for a Gray-coded pointer crossing clock
// domains. No logic precedes the first flop.
//   Clk        local clock
//   rst        synchronous, active-high reset (clears every stage)
//   async_gray Gray pointer from the other clock domain
//   sync_gray  synchronised pointer (last stage)
module gray_sync #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned STAGES = 2
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_gray,
    output logic [WIDTH-1:0] sync_gray
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge Clk) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= async_gray;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_gray = stage_q[STAGES-1];

endmodule

// File: rtl/gray_fifo_ptr.sv
// gray_fifo_ptr: Gray-code pointer unit for one side of a dual-clock FIFO.
// Holds an (ADDR_WIDTH+1)-bit binary/Gray pointer pair, synchronises the
// opposite side's Gray pointer and derives a registered full/empty flag,
// almost flag, fill level and a sticky refused-access error.
//   Clk            local clock
//   rst            synchronous, active-high reset
//   inc_in         advance request (write or read strobe)
//   remote_gray_in Gray pointer from the other clock domain (asynchronous)
//   ptr_gray_out   registered local Gray pointer, to the other domain
//   addr_out       registered RAM address (low bits of binary pointer)
//   flag_out       full when SIDE=1, empty when SIDE=0
//   almost_out     almost-full / almost-empty
//   level_out      fill level 0..DEPTH
//   err_out        sticky: an inc_in was refused while flag_out was high
module gray_fifo_ptr
    import gray_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned SIDE          = 0,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned ALMOST_THRESH = 2
) (
    input  logic                  Clk,
    input  logic                  rst,
    input  logic                  inc_in,
    input  logic [ADDR_WIDTH:0]   remote_gray_in,
    output logic [ADDR_WIDTH:0]   ptr_gray_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  flag_out,
    output logic                  almost_out,
    output logic [ADDR_WIDTH:0]   level_out,
    output logic                  err_out
);

    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    localparam logic [PW-1:0] ALMOST_FULL_LVL  = PW'(DEPTH - ALMOST_THRESH);
    localparam logic [PW-1:0] ALMOST_EMPTY_LVL = PW'(ALMOST_THRESH);

    // Read side starts empty (flag and almost high); write side starts clear.
    localparam logic FLAG_RST = (SIDE == SIDE_RD);

    logic [PW-1:0] bin_q, bin_d;
    logic [PW-1:0] gray_q, gray_d;
    logic [PW-1:0] level_q, level_d;
    logic          flag_q, flag_d;
    logic          almost_q, almost_d;
    logic          err_q, err_d;

    logic [PW-1:0] rsync;
    logic [PW-1:0] rbin;
    logic [PW-1:0] full_ref;
    logic          advance;

    gray_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .Clk        (Clk),
        .rst        (rst),
        .async_gray (remote_gray_in),
        .sync_gray  (rsync)
    );

    assign rbin = PW'(gray2bin(ptr_word_t'(rsync), PW));

    // Write pointer is full when it is one lap ahead: top two Gray bits
    // inverted, the rest equal.
    assign full_ref = {~rsync[PW-1:PW-2], rsync[PW-3:0]};

    always_comb begin
        advance  = inc_in & ~flag_q;
        bin_d    = advance ? bin_q + PW'(1) : bin_q;
        gray_d   = PW'(bin2gray(ptr_word_t'(bin_d), PW));
        err_d    = err_q | (inc_in & flag_q);
        flag_d   = 1'b0;
        level_d  = '0;
        almost_d = 1'b0;
        if (SIDE == SIDE_WR) begin
            flag_d   = (gray_d == full_ref);
            level_d  = bin_d - rbin;
            almost_d = (level_d >= ALMOST_FULL_LVL);
        end else begin
            flag_d   = (gray_d == rsync);
            level_d  = rbin - bin_d;
            almost_d = (level_d <= ALMOST_EMPTY_LVL);
        end
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            bin_q    <= '0;
            gray_q   <= '0;
            level_q  <= '0;
            flag_q   <= FLAG_RST;
            almost_q <= FLAG_RST;
            err_q    <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            gray_q   <= gray_d;
            level_q  <= level_d;
            flag_q   <= flag_d;
            almost_q <= almost_d;
            err_q    <= err_d;
        end
    end

    assign ptr_gray_out = gray_q;
    assign addr_out     = bin_q[ADDR_WIDTH-1:0];
    assign flag_out     = flag_q;
    assign almost_out   = almost_q;
    assign level_out    = level_q;
    assign err_out      = err_q;

endmodule
